// File: rtl/intadd_issuer.sv
// intadd_issuer: accepts one integer-add command, issues the cru_intadd micro-instruction,
// waits the adder latency and returns dst/st with the tag. Define INTADD_ISSUER_CNT_EN for counters.
module intadd_issuer #(
    parameter int LATENCY = 1,
    parameter int TAG_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_mode,
    input  logic [2:0]         cmd_sign,
    input  logic               cmd_update_st,
    input  logic [127:0]       cmd_src0,
    input  logic [127:0]       cmd_src1,
    input  logic [127:0]       cmd_src2,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic [127:0]       src_reg0,
    output logic [127:0]       src_reg1,
    output logic [127:0]       src_reg2,
    output logic [10:0]        cru_intadd,
    input  logic [127:0]       dst_reg0,
    input  logic [127:0]       dst_reg1,
    input  logic [127:0]       st,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [127:0]       rsp_dst0,
    output logic [127:0]       rsp_dst1,
    output logic [127:0]       rsp_st,
    output logic [TAG_W-1:0]   rsp_tag
`ifdef INTADD_ISSUER_CNT_EN
    ,
    output logic [31:0]        cnt_issued,
    output logic [31:0]        cnt_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t             r_state;
    logic               r_cmd_ready;
    logic [10:0]        r_cru;
    logic [127:0]       r_src0, r_src1, r_src2;
    logic [TAG_W-1:0]   r_tag;
    logic [3:0]         r_cnt;
    logic               r_rsp_valid;
    logic [127:0]       r_rsp_dst0, r_rsp_dst1, r_rsp_st;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [10:0]        w_enc;

    // Mode 0 is the 32-bit two-operand add: full precision, third sign unused.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_enc = '0;
        if (cmd_mode)
            w_enc = {1'b1, 2'b00, 2'b00, 2'b00, cmd_sign, cmd_update_st};
        else
            w_enc = {1'b1, 2'b11, 2'b11, 2'b11, cmd_sign[2], cmd_sign[1], 1'b0, cmd_update_st};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_cru       <= '0;
            r_src0      <= '0;
            r_src1      <= '0;
            r_src2      <= '0;
            r_tag       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dst0  <= '0;
            r_rsp_dst1  <= '0;
            r_rsp_st    <= '0;
            r_rsp_tag   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cru       <= w_enc;
                        r_src0      <= cmd_src0;
                        r_src1      <= cmd_src1;
                        r_src2      <= cmd_mode ? cmd_src2 : '0;
                        r_tag       <= cmd_tag;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cru   <= '0;
                    r_cnt   <= LAT_M1;
                    r_state <= (LATENCY == 1) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_rsp_dst0  <= dst_reg0;
                    r_rsp_dst1  <= dst_reg1;
                    r_rsp_st    <= st;
                    r_rsp_tag   <= r_tag;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // A waiting command is picked up in the next IDLE cycle, never bypassed here.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_src0      <= '0;
                        r_src1      <= '0;
                        r_src2      <= '0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_cru       <= '0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef INTADD_ISSUER_CNT_EN
    logic [31:0] r_cnt_issued, r_cnt_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_issued <= '0;
            r_cnt_stall  <= '0;
        end else begin
            if (r_state == S_ISSUE)
                r_cnt_issued <= r_cnt_issued + 32'd1;
            if (r_state == S_RESP && !rsp_ready)
                r_cnt_stall <= r_cnt_stall + 32'd1;
        end
    end

    assign cnt_issued = r_cnt_issued;
    assign cnt_stall  = r_cnt_stall;
`endif

    assign cmd_ready  = r_cmd_ready;
    assign cru_intadd = r_cru;
    assign src_reg0   = r_src0;
    assign src_reg1   = r_src1;
    assign src_reg2   = r_src2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_dst0   = r_rsp_dst0;
    assign rsp_dst1   = r_rsp_dst1;
    assign rsp_st     = r_rsp_st;
    assign rsp_tag    = r_rsp_tag;

endmodule

// File: tb/tb_intadd_issuer.sv
// Bench for intadd_issuer: two instances (LATENCY 1 and 4), each fed by a behavioural adder
// that only returns real results in the cycle LATENCY after issue, checked against a reference model.
module tb_intadd_issuer;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             cmd_valid [2];
    logic             cmd_ready [2];
    logic             cmd_mode [2];
    logic [2:0]       cmd_sign [2];
    logic             cmd_update_st [2];
    logic [127:0]     cmd_src0 [2];
    logic [127:0]     cmd_src1 [2];
    logic [127:0]     cmd_src2 [2];
    logic [TAG_W-1:0] cmd_tag [2];
    logic [127:0]     src_reg0 [2];
    logic [127:0]     src_reg1 [2];
    logic [127:0]     src_reg2 [2];
    logic [10:0]      cru_intadd [2];
    logic             rsp_valid [2];
    logic             rsp_ready [2];
    logic [127:0]     rsp_dst0 [2];
    logic [127:0]     rsp_dst1 [2];
    logic [127:0]     rsp_st [2];
    logic [TAG_W-1:0] rsp_tag [2];
`ifdef INTADD_ISSUER_CNT_EN
    logic [31:0]      cnt_issued [2];
    logic [31:0]      cnt_stall [2];
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [127:0]     d0;
        logic [127:0]     d1;
        logic [127:0]     st;
    } exp_t;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference encoding: mode 1 passes all signs with precision 00, mode 0 uses 11 and drops sign_s2.
    function automatic logic [10:0] exp_cru(input logic mode, input logic [2:0] sign, input logic upd);
        if (mode)
            return {1'b1, 6'b000000, sign, upd};
        return {1'b1, 6'b111111, sign[2], sign[1], 1'b0, upd};
    endfunction

    // Adder results as the behavioural adder defines them, from the command as submitted.
    function automatic exp_t exp_rsp(input logic mode, input logic [2:0] sign, input logic upd,
                                     input logic [TAG_W-1:0] tag,
                                     input logic [127:0] s0, input logic [127:0] s1, input logic [127:0] s2);
        exp_t e;
        e.tag = tag;
        e.d0  = s0 + s1;
        e.d1  = (s1 - s0) ^ (mode ? s2 : 128'd0);
        e.st  = {s0[116:0], exp_cru(mode, sign, upd)};
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 4;
        logic [127:0] dst0, dst1, stv;
        logic         p_valid = 1'b0;
        int           p_due = 0;
        logic [127:0] p_d0, p_d1, p_st;

        intadd_issuer #(.LATENCY(LAT), .TAG_W(TAG_W)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .cmd_valid    (cmd_valid[g]),
            .cmd_ready    (cmd_ready[g]),
            .cmd_mode     (cmd_mode[g]),
            .cmd_sign     (cmd_sign[g]),
            .cmd_update_st(cmd_update_st[g]),
            .cmd_src0     (cmd_src0[g]),
            .cmd_src1     (cmd_src1[g]),
            .cmd_src2     (cmd_src2[g]),
            .cmd_tag      (cmd_tag[g]),
            .src_reg0     (src_reg0[g]),
            .src_reg1     (src_reg1[g]),
            .src_reg2     (src_reg2[g]),
            .cru_intadd   (cru_intadd[g]),
            .dst_reg0     (dst0),
            .dst_reg1     (dst1),
            .st           (stv),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_dst0     (rsp_dst0[g]),
            .rsp_dst1     (rsp_dst1[g]),
            .rsp_st       (rsp_st[g]),
            .rsp_tag      (rsp_tag[g])
`ifdef INTADD_ISSUER_CNT_EN
            ,
            .cnt_issued   (cnt_issued[g]),
            .cnt_stall    (cnt_stall[g])
`endif
        );

        // Valid results only during the cycle LAT after issue; random garbage otherwise.
        always @(negedge clk) begin
            if (cru_intadd[g][10]) begin
                p_valid = 1'b1;
                p_due   = cyc + LAT;
                p_d0    = src_reg0[g] + src_reg1[g];
                p_d1    = (src_reg1[g] - src_reg0[g]) ^ src_reg2[g];
                p_st    = {src_reg0[g][116:0], cru_intadd[g]};
            end
            if (p_valid && p_due == cyc) begin
                dst0    = p_d0;
                dst1    = p_d1;
                stv     = p_st;
                p_valid = 1'b0;
            end else begin
                dst0 = rnd128();
                dst1 = rnd128();
                stv  = rnd128();
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drive_cmd(input int k, input logic mode, input logic [2:0] sign, input logic upd,
                             input logic [TAG_W-1:0] tag,
                             input logic [127:0] s0, input logic [127:0] s1, input logic [127:0] s2);
        cmd_mode[k]      = mode;
        cmd_sign[k]      = sign;
        cmd_update_st[k] = upd;
        cmd_tag[k]       = tag;
        cmd_src0[k]      = s0;
        cmd_src1[k]      = s1;
        cmd_src2[k]      = s2;
    endtask

    // One full command: issue word, latency to rsp_valid, optional response stall, handshake.
    task automatic run_cmd(input int k, input string name, input logic mode, input logic [2:0] sign,
                           input logic upd, input logic [TAG_W-1:0] tag,
                           input logic [127:0] s0, input logic [127:0] s1, input logic [127:0] s2,
                           input logic [10:0] want_cru, input int hold);
        exp_t e;
        int   n;
        bit   bad;
        e = exp_rsp(mode, sign, upd, tag, s0, s1, s2);
        rsp_ready[k] = (hold == 0);
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s[%0d] cmd_ready timeout: got %b want 1", name, k, cmd_ready[k]);
            return;
        end
        drive_cmd(k, mode, sign, upd, tag, s0, s1, s2);
        cmd_valid[k] = 1'b1;
        @(negedge clk);
        cmd_valid[k] = 1'b0;
        checks++;
        if (cru_intadd[k] !== want_cru || cmd_ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d] issue word: got cru=%h ready=%b want cru=%h ready=0",
                     name, k, cru_intadd[k], cmd_ready[k], want_cru);
        end
        checks++;
        if (src_reg0[k] !== s0 || src_reg1[k] !== s1 || src_reg2[k] !== (mode ? s2 : 128'd0)) begin
            errors++;
            $display("FAIL %s[%0d] operands: got src2=%h want src2=%h", name, k, src_reg2[k],
                     mode ? s2 : 128'd0);
        end
        n   = 0;
        bad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (cru_intadd[k] !== 11'd0 || cmd_ready[k] !== 1'b0) bad = 1'b1;
        end while (rsp_valid[k] !== 1'b1 && n < 40);
        checks++;
        if (n != lat_of(k) + 1 || bad) begin
            errors++;
            $display("FAIL %s[%0d] response latency: got %0d cycles (cru/ready leak=%0b) want %0d",
                     name, k, n, bad, lat_of(k) + 1);
        end
        checks++;
        if (rsp_dst0[k] !== e.d0 || rsp_dst1[k] !== e.d1 || rsp_st[k] !== e.st || rsp_tag[k] !== e.tag) begin
            errors++;
            $display("FAIL %s[%0d] response data: got tag=%h d0=%h st=%h want tag=%h d0=%h st=%h",
                     name, k, rsp_tag[k], rsp_dst0[k], rsp_st[k], e.tag, e.d0, e.st);
        end
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid[k] !== 1'b1 || cmd_ready[k] !== 1'b0 || rsp_dst0[k] !== e.d0 ||
                rsp_dst1[k] !== e.d1 || rsp_st[k] !== e.st || rsp_tag[k] !== e.tag) bad = 1'b1;
            @(negedge clk);
        end
        if (hold > 0) begin
            checks++;
            if (bad || rsp_valid[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] response hold: got unstable=%0b valid=%b want stable, valid=1",
                         name, k, bad, rsp_valid[k]);
            end
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid[k] !== 1'b0 || cmd_ready[k] !== 1'b1 ||
            {src_reg0[k], src_reg1[k], src_reg2[k]} !== 384'd0) begin
            errors++;
            $display("FAIL %s[%0d] after handshake: got valid=%b ready=%b want valid=0 ready=1 src=0",
                     name, k, rsp_valid[k], cmd_ready[k]);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (cmd_ready[k] !== 1'b1 || cru_intadd[k] !== 11'd0 || rsp_valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got ready=%b cru=%h valid=%b want 1/000/0",
                         k, cmd_ready[k], cru_intadd[k], rsp_valid[k]);
            end
            checks++;
            if ({src_reg0[k], src_reg1[k], src_reg2[k], rsp_dst0[k], rsp_dst1[k], rsp_st[k]} !== 768'd0 ||
                rsp_tag[k] !== '0) begin
                errors++;
                $display("FAIL reset_data[%0d]: got nonzero src/rsp registers, tag=%h want all 0",
                         k, rsp_tag[k]);
            end
`ifdef INTADD_ISSUER_CNT_EN
            checks++;
            if (cnt_issued[k] !== 32'd0 || cnt_stall[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", k, cnt_issued[k], cnt_stall[k]);
            end
`endif
        end
    endtask

    task automatic test_mode0();
        for (int k = 0; k < 2; k++)
            run_cmd(k, "mode0_add32", 1'b0, 3'b110, 1'b1, 4'h3, {4{32'h7FFFFFFF}}, {4{32'h00000001}},
                    rnd128(), 11'h7FD, 0);
    endtask

    task automatic test_mode1();
        for (int k = 0; k < 2; k++)
            run_cmd(k, "mode1_add3", 1'b1, 3'b101, 1'b1, 4'hA, rnd128(), rnd128(), rnd128(), 11'h40B, 0);
    endtask

    task automatic test_sign_force();
        for (int k = 0; k < 2; k++)
            run_cmd(k, "sign_s2_forced", 1'b0, 3'b111, 1'b1, 4'h5, rnd128(), rnd128(), rnd128(), 11'h7FD, 0);
    endtask

    task automatic test_stall();
        apply_reset();
        run_cmd(1, "stall5", 1'b1, 3'b010, 1'b0, 4'h7, rnd128(), rnd128(), rnd128(), 11'h404, 5);
`ifdef INTADD_ISSUER_CNT_EN
        checks++;
        if (cnt_stall[1] !== 32'd5 || cnt_issued[1] !== 32'd1) begin
            errors++;
            $display("FAIL stall_cnt: got stall=%0d issued=%0d want 5/1", cnt_stall[1], cnt_issued[1]);
        end
`endif
    endtask

    task automatic test_random();
        logic       mode, upd;
        logic [2:0] sign;
        logic [3:0] tag;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 2; k++) begin
                mode = 1'($urandom);
                upd  = 1'($urandom);
                sign = 3'($urandom);
                tag  = 4'($urandom);
                run_cmd(k, "random", mode, sign, upd, tag, rnd128(), rnd128(), rnd128(),
                        exp_cru(mode, sign, upd), int'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        rsp_ready[1] = 1'b1;
        drive_cmd(1, 1'b1, 3'b111, 1'b1, 4'hC, rnd128(), rnd128(), rnd128());
        cmd_valid[1] = 1'b1;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (cru_intadd[1] !== 11'd0 || rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_wait: got cru=%h valid=%b ready=%b want 000/0/1",
                     cru_intadd[1], rsp_valid[1], cmd_ready[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL dropped_cmd: got a response after reset want none");
        end
    endtask

    task automatic test_back_to_back(input int k);
        exp_t q[$];
        exp_t e, r;
        int   sent, got, last, budget, period_bad, data_bad;
        bit   accepted;
        apply_reset();
        rsp_ready[k] = 1'b1;
        sent = 0; got = 0; last = -1; budget = 0; period_bad = 0; data_bad = 0; accepted = 1'b0;
        drive_cmd(k, 1'($urandom), 3'($urandom), 1'($urandom), 4'($urandom), rnd128(), rnd128(), rnd128());
        cmd_valid[k] = 1'b1;
        while (got < 100 && budget < 2000) begin
            if (rsp_valid[k] === 1'b1) begin
                if (q.size() == 0) begin
                    data_bad++;
                end else begin
                    e = q.pop_front();
                    if (rsp_tag[k] !== e.tag || rsp_dst0[k] !== e.d0 || rsp_dst1[k] !== e.d1 ||
                        rsp_st[k] !== e.st) data_bad++;
                end
                if (last >= 0 && budget - last != lat_of(k) + 3) period_bad++;
                last = budget;
                got++;
            end
            if (accepted) begin
                if (sent < 100)
                    drive_cmd(k, 1'($urandom), 3'($urandom), 1'($urandom), 4'($urandom),
                              rnd128(), rnd128(), rnd128());
                else
                    cmd_valid[k] = 1'b0;
                accepted = 1'b0;
            end
            if (cmd_valid[k] && cmd_ready[k] === 1'b1) begin
                r = exp_rsp(cmd_mode[k], cmd_sign[k], cmd_update_st[k], cmd_tag[k],
                            cmd_src0[k], cmd_src1[k], cmd_src2[k]);
                q.push_back(r);
                sent++;
                accepted = 1'b1;
            end
            @(negedge clk);
            budget++;
        end
        cmd_valid[k] = 1'b0;
        checks++;
        if (got != 100 || data_bad != 0) begin
            errors++;
            $display("FAIL b2b_data[%0d]: got %0d responses, %0d wrong want 100, 0", k, got, data_bad);
        end
        checks++;
        if (period_bad != 0) begin
            errors++;
            $display("FAIL b2b_period[%0d]: got %0d off-period responses want 0 (period %0d)",
                     k, period_bad, lat_of(k) + 3);
        end
`ifdef INTADD_ISSUER_CNT_EN
        checks++;
        if (cnt_issued[k] !== 32'd100) begin
            errors++;
            $display("FAIL b2b_cnt_issued[%0d]: got %0d want 100", k, cnt_issued[k]);
        end
`endif
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
            drive_cmd(k, 1'b0, 3'b000, 1'b0, '0, '0, '0, '0);
        end
        test_reset();
        test_mode0();
        test_mode1();
        test_sign_force();
        test_stall();
        test_random();
        test_reset_in_wait();
        test_back_to_back(0);
        test_back_to_back(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/intadd_issuer.md
Name: intadd_issuer

Overview:
- Command-side initiator for the integer-add datapath. Accepts one add command at a time over a valid/ready handshake and encodes it into the 11-bit cru_intadd micro-instruction.
- Drives src_reg0..2 to the adder, waits the adder's fixed result latency, then captures dst_reg0, dst_reg1 and st.
- Returns the captured results with the command's tag over a valid/ready response handshake.
- Sits between the SMC instruction decoder and the intadd unit.

Parameters:
- LATENCY, 1, clock cycles from the cycle cru_intadd[10]=1 is presented until the adder outputs are valid; legal range 1..15.
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_mode  in  1  0 = 32-bit two-operand add; 1 = 8/4-bit three-operand add
- cmd_sign  in  3  {sign_s0, sign_s1, sign_s2}
- cmd_update_st  in  1  update status
- cmd_src0 / cmd_src1 / cmd_src2  in  128 each  operands
- cmd_tag  in  TAG_W  command identifier
- src_reg0 / src_reg1 / src_reg2  out  128 each  operands to adder
- cru_intadd  out  11  micro-instruction to adder
- dst_reg0 / dst_reg1  in  128 each  adder results
- st  in  128  adder status
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_dst0 / rsp_dst1 / rsp_st  out  128 each  captured results
- rsp_tag  out  TAG_W  tag of the completed command

Behaviour:
- Reset (async, rst_n low): state IDLE, cmd_ready=1, cru_intadd=0, src_reg0..2=0, rsp_valid=0, rsp_dst0/rsp_dst1/rsp_st=0, rsp_tag=0, latency counter=0. Any in-flight command is dropped with no response.
- cru_intadd bit map: [10] inst_valid, [9:8] precision_s0, [7:6] precision_s1, [5:4] precision_s2, [3] sign_s0, [2] sign_s1, [1] sign_s2, [0] update_st.
- Mode 0: all precisions 2'b11, sign_s2 forced 0, src_reg2 driven 0.
- Mode 1: all precisions 2'b00, all three signs passed through.
- State machine:
  - IDLE: cmd_ready=1. On cmd_valid, register the command fields and tag, then go to ISSUE.
  - ISSUE (exactly 1 cycle): cru_intadd = encoded word with [10]=1; src_reg* hold the operands; counter loaded with LATENCY-1. If LATENCY=1, go to CAPTURE; otherwise go to WAIT.
  - WAIT: cru_intadd=0; src_reg* held. Counter decrements each cycle; go to CAPTURE when it reaches 1.
  - CAPTURE (1 cycle): sample dst_reg0, dst_reg1 and st into the rsp_* registers; set rsp_valid=1; go to RESP.
  - RESP: hold rsp_* stable until rsp_valid & rsp_ready. On that cycle clear rsp_valid, zero src_reg*, and go to IDLE.
- cmd_ready is 1 only in IDLE, so at most one command is in flight.
- Throughput: with rsp_ready held high, one command completes every LATENCY+3 cycles.
- cru_intadd is nonzero only in ISSUE; it is never asserted for two consecutive cycles.
- rsp_* must not change while rsp_valid=1 and rsp_ready=0.
- cmd_valid while not in IDLE is ignored. The producer must hold the command until it sees cmd_ready.
- Simultaneous rsp_ready and a new cmd_valid in RESP: the response completes, and the new command is accepted in the following IDLE cycle (no bypass).

Optional Feature:
- Macro INTADD_ISSUER_CNT_EN.
- Defined: adds outputs cnt_issued[31:0] and cnt_stall[31:0], both reset to 0.
  - cnt_issued increments once per ISSUE cycle.
  - cnt_stall increments on every RESP cycle with rsp_ready=0.
  - Both counters wrap from FFFFFFFF to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Mode 0, sign=3'b110, update_st=1, src0 lanes 7FFFFFFF, src1 lanes 00000001, LATENCY=1 -> cru_intadd=11'h7FD for exactly one cycle, src_reg2=0; rsp_valid two cycles after ISSUE; rsp_dst0 equals dst_reg0 sampled in CAPTURE.
- Mode 1, sign=3'b101, update_st=1, tag=4'hA -> cru_intadd=11'h40B for one cycle; rsp_tag=4'hA; rsp_dst0, rsp_dst1 and rsp_st match the adder outputs.
- Mode 0, sign=3'b111 -> cru_intadd[1]=0 (sign_s2 forced 0), cru_intadd=11'h7FD.
- LATENCY=4, rsp_ready held low for 5 cycles -> 3 WAIT cycles; rsp_* stable throughout the hold; cmd_ready=0 until one cycle after the handshake; with the macro defined, cnt_stall=5.
- rst_n pulsed low during WAIT -> immediate cru_intadd=0, rsp_valid=0, cmd_ready=1; no response is ever produced for that tag.
- 100 back-to-back random commands with rsp_ready=1 -> responses in order, tags match, period exactly LATENCY+3 cycles, cnt_issued=100.
